// File: rtl/mod_counter_bank.sv
// Bank of N independent W-bit limit counters (up/down, load, wrap/saturate) with terminal-count pulses.
// One-cycle latency from en/load to count/tc, all outputs registered; always accepts input, no backpressure.
module mod_counter_bank #(
    parameter int W           = 10,
    parameter int N           = 4,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     en,
    input  logic [N-1:0]     up,
    input  logic [N-1:0]     load,
    input  logic [N*W-1:0]   load_val,
    input  logic [N*W-1:0]   limit,
    input  logic             mode_wr,
    input  logic             sat_in,
    output logic [N*W-1:0]   count,
    output logic [N-1:0]     tc,
    output logic             sat_mode
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_mode <= SAT_DEFAULT;
        end else if (mode_wr) begin
            sat_mode <= sat_in;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [W-1:0] cnt_q;
        logic         tc_q;
        logic [W-1:0] lim;
        logic [W-1:0] ldv;

        assign lim = limit[i*W +: W];
        assign ldv = load_val[i*W +: W];

        // Boundary compare precedes the +1/-1, so neither step can overflow W bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
            end else if (load[i]) begin
                cnt_q <= (ldv > lim) ? lim : ldv;
                tc_q  <= 1'b0;
            end else if (en[i]) begin
                if (cnt_q > lim) begin
                    cnt_q <= lim;
                    tc_q  <= 1'b0;
                end else if (up[i]) begin
                    if (cnt_q == lim) begin
                        cnt_q <= sat_mode ? lim : '0;
                        tc_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        tc_q  <= 1'b0;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        cnt_q <= sat_mode ? '0 : lim;
                        tc_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        tc_q  <= 1'b0;
                    end
                end
            end else begin
                tc_q <= 1'b0;
            end
        end

        assign count[i*W +: W] = cnt_q;
        assign tc[i]           = tc_q;

`ifdef FORMAL
        ap_f0: assert property (@(posedge clk) disable iff (!rst_n)
            $past(rst_n) && $past(en[i] | load[i]) |-> cnt_q <= $past(lim));
        ap_f1: assert property (@(posedge clk) disable iff (!rst_n)
            $past(rst_n) && tc_q |-> (cnt_q == '0) || (cnt_q == $past(lim)));
        ap_f2: assert property (@(posedge clk) disable iff (!rst_n)
            $past(rst_n) && !$past(en[i] | load[i]) |-> (cnt_q == $past(cnt_q)) && !tc_q);
        ap_f3: assert property (@(posedge clk) disable iff (!rst_n)
            $past(rst_n) && $past(load[i]) |-> !tc_q);
`endif
    end

`ifdef FORMAL
    cp_wrap_tc: cover property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) && !sat_mode && $rose(tc[0]));
`endif

endmodule

// File: tb/tb_mod_counter_bank.sv
// Table-driven and randomized bench for mod_counter_bank at W=4, N=2.
module tb_mod_counter_bank;
    localparam int W = 4;
    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     en, up, load;
    logic [N*W-1:0]   load_val, limit;
    logic             mode_wr, sat_in;
    logic [N*W-1:0]   count;
    logic [N-1:0]     tc;
    logic             sat_mode;

    int checks = 0;
    int errors = 0;

    mod_counter_bank #(.W(W), .N(N), .SAT_DEFAULT(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .mode_wr  (mode_wr),
        .sat_in   (sat_in),
        .count    (count),
        .tc       (tc),
        .sat_mode (sat_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en, up, load;
        logic [3:0] lv0, lv1, lim0, lim1;
        logic       mw, si;
        logic [3:0] c0, c1;
        logic [1:0] tcx;
        logic       sm;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] e, u, l, input logic [3:0] lv0, lv1, lm0, lm1,
                       input logic mw, si, input logic [3:0] c0, c1, input logic [1:0] t, input logic sm);
        vec_t v;
        v.en = e; v.up = u; v.load = l; v.lv0 = lv0; v.lv1 = lv1; v.lim0 = lm0; v.lim1 = lm1;
        v.mw = mw; v.si = si; v.c0 = c0; v.c1 = c1; v.tcx = t; v.sm = sm;
        vq.push_back(v);
    endtask

    task automatic apply(input logic [1:0] e, u, l, input logic [3:0] lv0, lv1, lm0, lm1,
                         input logic mw, si);
        en = e; up = u; load = l;
        load_val = {lv1, lv0};
        limit = {lm1, lm0};
        mode_wr = mw; sat_in = si;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next state from modular arithmetic over the range 0..limit.
    int mc[N];
    int mtc[N];
    bit msat;

    task automatic model_step();
        int c, lim, lv;
        for (int ch = 0; ch < N; ch++) begin
            c   = mc[ch];
            lim = int'(limit[ch*W +: W]);
            lv  = int'(load_val[ch*W +: W]);
            if (load[ch]) begin
                mc[ch] = (lv < lim) ? lv : lim;
                mtc[ch] = 0;
            end else if (en[ch]) begin
                if (c > lim) begin
                    mc[ch] = lim; mtc[ch] = 0;
                end else if (up[ch]) begin
                    mtc[ch] = (c == lim);
                    mc[ch]  = msat ? ((c + 1 < lim) ? c + 1 : lim) : (c + 1) % (lim + 1);
                end else begin
                    mtc[ch] = (c == 0);
                    mc[ch]  = msat ? ((c > 0) ? c - 1 : 0) : (c + lim) % (lim + 1);
                end
            end else begin
                mtc[ch] = 0;
            end
        end
        if (mode_wr) msat = sat_in;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
        #12;
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_tc", 32'(tc), 32'h0);
        chk("reset_sat", 32'(sat_mode), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // wrap count to 5 and back
        for (int k = 1; k <= 6; k++)
            add(2'b01, 2'b01, 2'b00, 0, 0, 5, 7, 1'b0, 1'b0, 4'(k % 6), 0, (k == 6) ? 2'b01 : 2'b00, 1'b0);
        // saturate up then down
        add(2'b00, 2'b01, 2'b00, 0, 0, 3, 7, 1'b1, 1'b1, 0, 0, 2'b00, 1'b1);
        add(2'b01, 2'b01, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 1, 0, 2'b00, 1'b1);
        add(2'b01, 2'b01, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 2, 0, 2'b00, 1'b1);
        add(2'b01, 2'b01, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 3, 0, 2'b00, 1'b1);
        add(2'b01, 2'b01, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 3, 0, 2'b01, 1'b1);
        add(2'b01, 2'b01, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 3, 0, 2'b01, 1'b1);
        add(2'b01, 2'b00, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 2, 0, 2'b00, 1'b1);
        add(2'b01, 2'b00, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 1, 0, 2'b00, 1'b1);
        add(2'b01, 2'b00, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 0, 0, 2'b00, 1'b1);
        add(2'b01, 2'b00, 2'b00, 0, 0, 3, 7, 1'b0, 1'b0, 0, 0, 2'b01, 1'b1);
        // load clamps and wins over en, then limit lowered below count
        add(2'b01, 2'b00, 2'b01, 12, 0, 9, 7, 1'b0, 1'b0, 9, 0, 2'b00, 1'b1);
        add(2'b01, 2'b00, 2'b00, 0, 0, 4, 7, 1'b0, 1'b0, 4, 0, 2'b00, 1'b1);
        // back to wrap, then channel 1 down-wrap
        add(2'b00, 2'b00, 2'b00, 0, 0, 4, 7, 1'b1, 1'b0, 4, 0, 2'b00, 1'b0);
        add(2'b10, 2'b00, 2'b00, 0, 0, 4, 7, 1'b0, 1'b0, 4, 7, 2'b10, 1'b0);
        add(2'b10, 2'b00, 2'b00, 0, 0, 4, 7, 1'b0, 1'b0, 4, 6, 2'b00, 1'b0);

        foreach (vq[k]) begin
            apply(vq[k].en, vq[k].up, vq[k].load, vq[k].lv0, vq[k].lv1, vq[k].lim0, vq[k].lim1,
                  vq[k].mw, vq[k].si);
            tick();
            chk($sformatf("vec%0d_c0", k), 32'(count[3:0]), 32'(vq[k].c0));
            chk($sformatf("vec%0d_c1", k), 32'(count[7:4]), 32'(vq[k].c1));
            chk($sformatf("vec%0d_tc", k), 32'(tc), 32'(vq[k].tcx));
            chk($sformatf("vec%0d_sat", k), 32'(sat_mode), 32'(vq[k].sm));
        end

        // limit=0: first step clamps the out-of-range count, then every step is a boundary
        apply(2'b01, 2'b01, 2'b00, 0, 0, 0, 7, 1'b0, 1'b0);
        tick();
        chk("lim0_clamp_c0", 32'(count[3:0]), 32'h0);
        chk("lim0_clamp_tc", 32'(tc[0]), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("lim0_c0_%0d", k), 32'(count[3:0]), 32'h0);
            chk($sformatf("lim0_tc_%0d", k), 32'(tc[0]), 32'h1);
        end

        // full range on channel 1
        apply(2'b00, 2'b00, 2'b10, 0, 0, 0, 15, 1'b0, 1'b0);
        tick();
        chk("full_load", 32'(count[7:4]), 32'h0);
        apply(2'b10, 2'b10, 2'b00, 0, 0, 0, 15, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("full_c1_%0d", k), 32'(count[7:4]), 32'(k % 16));
            chk($sformatf("full_tc1_%0d", k), 32'(tc[1]), (k == 16) ? 32'h1 : 32'h0);
            chk($sformatf("full_x_%0d", k), 32'($isunknown(count)), 32'h0);
        end

        // async reset mid-operation while tc0 is high
        apply(2'b00, 2'b00, 2'b00, 0, 0, 5, 7, 1'b1, 1'b1);
        tick();
        apply(2'b00, 2'b00, 2'b01, 5, 0, 5, 7, 1'b0, 1'b0);
        tick();
        apply(2'b01, 2'b01, 2'b00, 0, 0, 5, 7, 1'b0, 1'b0);
        tick();
        chk("prerst_c0", 32'(count[3:0]), 32'h5);
        chk("prerst_tc0", 32'(tc[0]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_c0", 32'(count[3:0]), 32'h0);
        chk("midrst_tc", 32'(tc), 32'h0);
        chk("midrst_sat", 32'(sat_mode), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postrst_c0", 32'(count[3:0]), 32'h1);
        chk("postrst_tc0", 32'(tc[0]), 32'h0);

        // randomized phase against the model
        rst_n = 1'b0;
        #3;
        for (int ch = 0; ch < N; ch++) begin mc[ch] = 0; mtc[ch] = 0; end
        msat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                en[ch]   = ($urandom_range(0, 3) != 0);
                up[ch]   = $urandom_range(0, 1);
                load[ch] = ($urandom_range(0, 9) == 0);
                load_val[ch*W +: W] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 11) == 0)
                    limit[ch*W +: W] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                                     : 4'($urandom_range(0, 15));
            end
            mode_wr = ($urandom_range(0, 14) == 0);
            sat_in  = $urandom_range(0, 1);
            model_step();
            tick();
            chk($sformatf("rnd%0d_c0", k), 32'(count[3:0]), 32'(mc[0]));
            chk($sformatf("rnd%0d_c1", k), 32'(count[7:4]), 32'(mc[1]));
            chk($sformatf("rnd%0d_tc", k), 32'(tc), 32'({mtc[1][0], mtc[0][0]}));
            chk($sformatf("rnd%0d_sat", k), 32'(sat_mode), 32'(msat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_counter_bank.md
Name: mod_counter_bank

Overview:
- Bank of N independent W-bit counters, each with a runtime limit, up/down direction, synchronous load and a wrap or saturate mode.
- Each channel emits a registered terminal-count pulse.
- Generalised successor of the single fixed-modulus free-running counter; used as the shared timer/sequencer primitive and as a formal-verification benchmark.
- Embedded safety properties are compiled under FORMAL.

Parameters:
- W, 10, counter width per channel in bits (W >= 2).
- N, 4, number of independent channels (N >= 1).
- SAT_DEFAULT, 0, reset value of the internal mode bit (0 = wrap, 1 = saturate).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  N  per-channel count enable.
- up  input  N  per-channel direction (1 = increment, 0 = decrement).
- load  input  N  per-channel synchronous load strobe.
- load_val  input  N*W  per-channel load value; channel i uses bits [i*W +: W].
- limit  input  N*W  per-channel inclusive maximum; channel i uses bits [i*W +: W].
- mode_wr  input  1  writes sat_in into the mode register.
- sat_in  input  1  new mode value (1 = saturate).
- count  output  N*W  per-channel registered count.
- tc  output  N  per-channel registered terminal-count pulse.
- sat_mode  output  1  current mode register value.

Behaviour:
- Reset: async assert clears all count to 0, tc to 0, sat_mode to SAT_DEFAULT. Deassertion is used synchronously; first update on the first rising edge with rst_n=1.
- Mode: if mode_wr=1, sat_mode <= sat_in at the edge. The new mode affects steps from the next cycle onward.
- Per-channel priority: load > en > hold. Channels never interact.
- Load: count <= min(load_val, limit); tc <= 0.
- Out-of-range: if en=1 and count > limit (limit lowered at runtime), count <= limit, tc <= 0, regardless of direction.
- Up step (en=1, up=1, count < limit): count <= count+1, tc <= 0.
- Up at boundary (count == limit):
  - wrap mode: count <= 0, tc <= 1.
  - saturate mode: count holds at limit, tc <= 1.
- Down step (en=1, up=0, 0 < count <= limit): count <= count-1, tc <= 0.
- Down at boundary (count == 0):
  - wrap mode: count <= limit, tc <= 1.
  - saturate mode: count holds at 0, tc <= 1.
- Hold (en=0, load=0): count unchanged, tc <= 0.
- tc width and timing: tc is high for exactly the one cycle following a boundary step. Consecutive boundary steps (saturate, or limit=0) keep tc high on consecutive cycles.
- limit=0: count is always 0; every enabled step is a boundary step, so tc=1.
- limit = all-ones: full 2^W-state range; the increment never overflows because the boundary check precedes +1.
- Arithmetic is W-bit unsigned. No intermediate value wider than W+1 bits.
- Latency: one cycle from en/load to count/tc; no combinational input-to-output path.
- Formal properties (under FORMAL, checked only when rst_n and $past(rst_n)), per channel i:
  - F0: $past(en[i]|load[i]) -> count[i] <= $past(limit[i]).
  - F1: tc[i] -> count[i] == 0 or count[i] == $past(limit[i]).
  - F2: !$past(en[i]|load[i]) -> count[i] == $past(count[i]) and !tc[i].
  - F3: $past(load[i]) -> !tc[i].
- Formal environment: rst_n is low in the initial state only. Cover: tc[0] rises in wrap mode.

Test Plan:
- W=4, N=2, wrap, limit0=5, en0=1, up0=1 from reset: count0 goes 0,1,2,3,4,5,0; tc0=1 only in the cycle count0 returns to 0. Channel 1 (en1=0) stays at 0.
- Saturate (mode_wr=1, sat_in=1), limit0=3, count up from 0: count0 goes 1,2,3,3,3; tc0 high on every cycle after reaching 3. Switch to down: 2,1,0,0 with tc0 high while held at 0.
- Load priority: load0=1, load_val0=12, limit0=9, en0=1 in the same cycle: next count0=9, tc0=0. Next cycle limit0=4 with en0=1: count0=4, tc0=0.
- Down wrap: limit1=7, count1=0, en1=1, up1=0 in wrap mode: count1=7, tc1=1; next step count1=6, tc1=0.
- limit=0 and full range: limit0=0 with en0 held gives count0=0 and tc0=1 every cycle. limit1=15 counts 0..15 then 0 with a single tc1 pulse; no X and no overflow.
- Reset mid-operation: assert rst_n low while count0=5, tc0=1: count0=0, tc0=0 and sat_mode=SAT_DEFAULT immediately, with no clock edge. After release, counting resumes from 0.
